// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dino_pkg
// Description : Shared state encoding and screen constants for the dino sprite.
// Revision    : 1.0
// ============================================================================
package dino_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } dino_state_t;

    localparam int C_SCREEN_H = 240;
    localparam int C_GROUND_Y = 181;

endpackage
`default_nettype wire

// File: rtl/dino_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : dino_tick_gen
// Description : Divides clk into a one-cycle physics strobe; holds while frozen.
// Revision    : 1.0
// ============================================================================
module dino_tick_gen #(
    parameter int TICK_DIV = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == C_LAST);
    assign tick   = w_wrap && !freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!freeze) begin
            r_cnt <= w_wrap ? '0 : r_cnt + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dino_jump_physics.sv
`default_nettype none
// ============================================================================
// Module      : dino_jump_physics
// Description : Per-tick jump/gravity engine producing the dino sprite Y.
// Revision    : 1.0
// ============================================================================
module dino_jump_physics
    import dino_pkg::*;
#(
    parameter int Y_W       = $clog2(C_SCREEN_H),
    parameter int V_W       = 6,
    parameter int GROUND_Y  = C_GROUND_Y,
    parameter int V0        = 12,
    parameter int V_SHORT   = 4,
    parameter int GRAVITY   = 1,
    parameter int FAST_G    = 3,
    parameter int MAX_JUMPS = 2,
    parameter int TICK_DIV  = 200000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             jump_btn,
    input  logic                             duck_btn,
    input  logic                             freeze,
    output logic [Y_W-1:0]                   dino_y,
    output logic                             airborne,
    output logic                             ducking,
    output logic [$clog2(MAX_JUMPS+1)-1:0]   jump_count,
    output logic                             tick
);

    localparam int E_W  = Y_W + 2;
    localparam int JC_W = $clog2(MAX_JUMPS + 1);

    localparam logic signed [V_W-1:0] C_VEL_ZERO = '0;
    localparam logic signed [V_W-1:0] C_V0       = V_W'(V0);
    localparam logic signed [V_W-1:0] C_V_SHORT  = V_W'(V_SHORT);
    localparam logic signed [V_W:0]   C_V_MIN    = (V_W+1)'(-(2 ** (V_W - 1)));
    localparam logic signed [V_W:0]   C_G_NORM   = (V_W+1)'(GRAVITY);
    localparam logic signed [V_W:0]   C_G_FAST   = (V_W+1)'(FAST_G);
    localparam logic signed [E_W-1:0] C_GROUND_E = E_W'(GROUND_Y);
    localparam logic [Y_W-1:0]        C_REST_Y   = Y_W'(GROUND_Y);
    localparam logic [JC_W-1:0]       C_MAX_JC   = JC_W'(MAX_JUMPS);
    localparam logic [JC_W-1:0]       C_JC_ONE   = JC_W'(1);

    dino_state_t               r_state, w_state_nx;
    logic [Y_W-1:0]            r_y, w_y_nx;
    logic signed [V_W-1:0]     r_vel, w_vel_nx;
    logic [JC_W-1:0]           r_jc, w_jc_nx;
    logic                      r_jump_q;
    logic                      r_jump_pend;
    logic                      r_ducking;

    logic                      w_tick;
    logic                      w_rise;
    logic signed [E_W-1:0]     w_y_cur;
    logic signed [V_W-1:0]     w_vel_a, w_vel_m, w_vel_sat;
    logic signed [E_W-1:0]     w_y_a, w_y_n;
    logic                      w_land_a, w_grant, w_air_eff;
    logic [JC_W-1:0]           w_jc_m;
    logic signed [V_W:0]       w_vel_dec;

    dino_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .tick   (w_tick)
    );

    assign w_rise  = jump_btn && !r_jump_q;
    assign w_y_cur = $signed({2'b00, r_y});

    always_comb begin
        w_vel_a    = r_vel;
        w_vel_m    = r_vel;
        w_vel_sat  = r_vel;
        w_y_n      = w_y_cur;
        w_jc_m     = r_jc;
        w_state_nx = r_state;
        w_y_nx     = r_y;
        w_vel_nx   = r_vel;
        w_jc_nx    = r_jc;

        if (r_state == GROUND) begin
            w_vel_a = C_VEL_ZERO;
        end else if (r_state == RISE && !jump_btn && r_vel > C_V_SHORT) begin
            w_vel_a = C_V_SHORT;
        end

        // Motion without a grant decides whether this tick would land; a
        // pending jump on a landing tick then restarts from the ground.
        w_y_a     = w_y_cur - E_W'(w_vel_a);
        w_land_a  = (w_y_a >= C_GROUND_E) && (w_vel_a <= C_VEL_ZERO);
        w_grant   = r_jump_pend && (w_land_a || r_jc < C_MAX_JC);
        w_air_eff = (r_state != GROUND) && !(w_grant && w_land_a);

        w_vel_m = w_vel_a;
        w_y_n   = w_y_a;
        if (w_grant) begin
            w_vel_m = C_V0;
            w_y_n   = (w_land_a ? C_GROUND_E : w_y_cur) - E_W'(C_V0);
            w_jc_m  = (w_land_a ? '0 : r_jc) + C_JC_ONE;
        end

        w_vel_dec = (V_W+1)'(w_vel_m) - ((w_air_eff && duck_btn) ? C_G_FAST : C_G_NORM);
        w_vel_sat = (w_vel_dec < C_V_MIN) ? C_V_MIN[V_W-1:0] : w_vel_dec[V_W-1:0];

        if (!w_grant && w_y_n >= C_GROUND_E && w_vel_m <= C_VEL_ZERO) begin
            w_state_nx = GROUND;
            w_y_nx     = C_REST_Y;
            w_vel_nx   = C_VEL_ZERO;
            w_jc_nx    = '0;
        end else if (w_y_n[E_W-1]) begin
            w_state_nx = FALL;
            w_y_nx     = '0;
            w_vel_nx   = C_VEL_ZERO;
            w_jc_nx    = w_jc_m;
        end else begin
            w_state_nx = (w_vel_sat > C_VEL_ZERO) ? RISE : FALL;
            w_y_nx     = w_y_n[Y_W-1:0];
            w_vel_nx   = w_vel_sat;
            w_jc_nx    = w_jc_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= GROUND;
            r_y         <= C_REST_Y;
            r_vel       <= C_VEL_ZERO;
            r_jc        <= '0;
            r_jump_q    <= 1'b0;
            r_jump_pend <= 1'b0;
            r_ducking   <= 1'b0;
        end else begin
            r_jump_q  <= jump_btn;
            r_ducking <= duck_btn && (r_state == GROUND);

            // An edge arriving in the tick cycle survives into the next tick.
            if (freeze) begin
                r_jump_pend <= 1'b0;
            end else if (w_tick) begin
                r_jump_pend <= w_rise;
            end else if (w_rise) begin
                r_jump_pend <= 1'b1;
            end

            if (w_tick) begin
                r_state <= w_state_nx;
                r_y     <= w_y_nx;
                r_vel   <= w_vel_nx;
                r_jc    <= w_jc_nx;
            end
        end
    end

    assign dino_y     = r_y;
    assign airborne   = (r_state != GROUND);
    assign ducking    = r_ducking;
    assign jump_count = r_jc;
    assign tick       = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_dino_jump_physics.sv
`default_nettype none
// ============================================================================
// Module      : tb_dino_jump_physics
// Description : Directed bench for dino_jump_physics with TICK_DIV = 4.
// Revision    : 1.0
// ============================================================================
module tb_dino_jump_physics;

    logic       clk = 1'b0;
    logic       rst;
    logic       jump_a, duck_a, freeze_a, jump_b;
    logic [7:0] y_a, y_b;
    logic       air_a, air_b, dk_a, dk_b, tk_a, tk_b;
    logic [1:0] jc_a, jc_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int tk_seen;
    int y_moved;

    int exp_hop[4]  = '{165, 162, 160, 159};
    int exp_duck[4] = '{103, 106, 112, 121};
    int exp_ceil[7] = '{0, 1, 3, 6, 10, 15, 20};

    always #5 clk = ~clk;

    dino_jump_physics #(
        .TICK_DIV (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .jump_btn   (jump_a),
        .duck_btn   (duck_a),
        .freeze     (freeze_a),
        .dino_y     (y_a),
        .airborne   (air_a),
        .ducking    (dk_a),
        .jump_count (jc_a),
        .tick       (tk_a)
    );

    dino_jump_physics #(
        .GROUND_Y (20),
        .TICK_DIV (4)
    ) u_dut_ceil (
        .clk        (clk),
        .rst        (rst),
        .jump_btn   (jump_b),
        .duck_btn   (1'b0),
        .freeze     (1'b0),
        .dino_y     (y_b),
        .airborne   (air_b),
        .ducking    (dk_b),
        .jump_count (jc_b),
        .tick       (tk_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the tick's update edge.
    task automatic wait_tick(input bit use_b);
        int guard;
        guard = 0;
        while (((use_b ? tk_b : tk_a) !== 1'b1) && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        chk("tick_seen", 32'(use_b ? tk_b : tk_a), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        jump_a   = 1'b0;
        duck_a   = 1'b0;
        freeze_a = 1'b0;
        jump_b   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_y", y_a, 181);
        chk("reset_air", air_a, 0);
        chk("reset_jc", jc_a, 0);
        chk("reset_tick", tk_a, 0);
        chk("reset_duck", dk_a, 0);
        chk("reset_y_ceil", y_b, 20);

        // Full jump, button held
        jump_a = 1'b1;
        wait_tick(0);
        chk("full_t1_y", y_a, 169);
        chk("full_t1_air", air_a, 1);
        chk("full_t1_jc", jc_a, 1);
        repeat (11) wait_tick(0);
        chk("full_peak_y", y_a, 103);
        repeat (12) wait_tick(0);
        chk("full_t24_y", y_a, 169);
        chk("full_t24_air", air_a, 1);
        wait_tick(0);
        chk("full_land_y", y_a, 181);
        chk("full_land_air", air_a, 0);
        chk("full_land_jc", jc_a, 0);
        jump_a = 1'b0;

        // Short hop
        @(negedge clk);
        jump_a = 1'b1;
        wait_tick(0);
        chk("hop_t1_y", y_a, 169);
        jump_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_tick(0);
            chk("hop_rise_y", y_a, exp_hop[i]);
        end
        repeat (7) wait_tick(0);
        chk("hop_t12_y", y_a, 180);
        wait_tick(0);
        chk("hop_land_y", y_a, 181);
        chk("hop_land_air", air_a, 0);

        // Freeze mid-air, then duck while falling
        @(negedge clk);
        jump_a = 1'b1;
        repeat (3) wait_tick(0);
        chk("frz_pre_y", y_a, 148);
        freeze_a = 1'b1;
        tk_seen  = 0;
        y_moved  = 0;
        repeat (40) begin
            @(negedge clk);
            if (tk_a !== 1'b0) tk_seen++;
            if (y_a !== 8'd148) y_moved++;
        end
        chk("frz_ticks", tk_seen, 0);
        chk("frz_y_moves", y_moved, 0);
        freeze_a = 1'b0;
        wait_tick(0);
        chk("frz_resume_y", y_a, 139);
        repeat (8) wait_tick(0);
        chk("duck_peak_y", y_a, 103);
        duck_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tick(0);
            chk("duck_fall_y", y_a, exp_duck[i]);
        end
        chk("duck_air_ducking", dk_a, 0);
        repeat (3) wait_tick(0);
        chk("duck_t19_y", y_a, 166);
        wait_tick(0);
        chk("duck_land_y", y_a, 181);
        chk("duck_land_jc", jc_a, 0);
        @(posedge clk);
        @(negedge clk);
        chk("ground_ducking", dk_a, 1);
        duck_a = 1'b0;
        jump_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ground_unduck", dk_a, 0);

        // Double jump, third press ignored
        jump_a = 1'b1;
        wait_tick(0);
        chk("dbl_t1_y", y_a, 169);
        wait_tick(0);
        chk("dbl_t2_y", y_a, 158);
        jump_a = 1'b0;
        @(negedge clk);
        jump_a = 1'b1;
        wait_tick(0);
        chk("dbl_t3_y", y_a, 146);
        chk("dbl_t3_jc", jc_a, 2);
        jump_a = 1'b0;
        @(negedge clk);
        jump_a = 1'b1;
        wait_tick(0);
        chk("dbl_third_y", y_a, 135);
        chk("dbl_third_jc", jc_a, 2);
        repeat (24) wait_tick(0);
        chk("dbl_t28_y", y_a, 171);
        wait_tick(0);
        chk("dbl_land_y", y_a, 181);
        chk("dbl_land_jc", jc_a, 0);
        chk("dbl_land_air", air_a, 0);

        // Reset mid-jump overrides freeze
        jump_a = 1'b0;
        @(negedge clk);
        jump_a = 1'b1;
        wait_tick(0);
        chk("rst_pre_y", y_a, 169);
        freeze_a = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_y", y_a, 181);
        chk("rst_mid_air", air_a, 0);
        chk("rst_mid_jc", jc_a, 0);
        rst      = 1'b0;
        freeze_a = 1'b0;
        jump_a   = 1'b0;

        // Ceiling clamp with GROUND_Y = 20
        @(negedge clk);
        jump_b = 1'b1;
        wait_tick(1);
        chk("ceil_t1_y", y_b, 8);
        wait_tick(1);
        chk("ceil_t2_y", y_b, 0);
        chk("ceil_t2_air", air_b, 1);
        for (int i = 0; i < 7; i++) begin
            wait_tick(1);
            chk("ceil_fall_y", y_b, exp_ceil[i]);
        end
        chk("ceil_land_air", air_b, 0);
        chk("ceil_land_jc", jc_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
